// File: rtl/banked_sram_ctrl.sv
// banked_sram_ctrl
//   Byte-enabled single-port data memory built from NUM_BANKS equal banks of
//   2^BANK_ADDR_WIDTH words. All banks are zeroed in parallel after reset.
//   Requests are served only after that, with one-cycle latency.
//   Addresses whose bank field is >= NUM_BANKS are reported through oor.
//
//   Optional feature macro: SRAM_BYTE_PARITY_EN
//     When defined, every byte lane stores one even-parity bit, and reads
//     report a stored-vs-recomputed mismatch on parity_err.
//     When undefined, parity_err is tied to 0.
//
//   Ports
//     clk        : sole clock
//     reset      : synchronous, active-high
//     addr       : word address (bank | offset), sampled with re/we
//     din        : write data
//     we         : per-byte write enable; nonzero = write (wins over re)
//     re         : read request
//     ack        : one-cycle completion pulse, one cycle after acceptance
//     dout       : read data; holds the last read value
//     oor        : out-of-range flag, valid with ack
//     init_done  : high once zero-initialisation has completed
//     parity_err : byte parity mismatch on read, valid with ack
//
//   state | meaning
//   INIT  | zeroing offset cnt_q in every bank, one offset per cycle
//   IDLE  | serving requests until the next reset
module banked_sram_ctrl #(
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic                    re,
  output logic                    ack,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    oor,
  output logic                    init_done,
  output logic                    parity_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << BANK_ADDR_WIDTH;
  localparam int BW    = ADDR_WIDTH - BANK_ADDR_WIDTH;

  typedef enum logic {INIT, IDLE} state_t;

  state_t                     state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                       init_wr;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q [NUM_BANKS];

  logic [BW-1:0]              bank_idx;
  logic [BANK_ADDR_WIDTH-1:0] offset;
  logic                       in_range;
  logic                       accept_wr, accept_rd;

  logic            ack_q, oor_q, init_done_q, dout_zero_q;
  logic [BW-1:0]   bank_sel_q;
  logic [DATA_WIDTH-1:0] dout_mux;

  assign bank_idx = addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  assign offset   = addr[BANK_ADDR_WIDTH-1:0];
  assign in_range = (32'(bank_idx) < NUM_BANKS);

  // A request coinciding with reset is dropped so no ack can follow it.
  assign accept_wr = init_done_q && !reset && (we != '0);
  assign accept_rd = init_done_q && !reset && (we == '0) && re;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    case (state_q)
      INIT: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == {BANK_ADDR_WIDTH{1'b1}}) state_d = IDLE;
      end
      default: ;
    endcase
  end

`ifdef SRAM_BYTE_PARITY_EN
  logic [LANES-1:0] par_mem [NUM_BANKS][DEPTH];
  logic             par_mismatch;
  logic             par_err_q;

  always_comb begin
    par_mismatch = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_idx == BW'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          par_mismatch = par_mismatch |
                         (par_mem[b][offset][l] ^ (^mem[b][offset][l*8 +: 8]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (init_wr) begin
        par_mem[b][cnt_q] <= '0;
      end else if (accept_wr && bank_idx == BW'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          if (we[l]) par_mem[b][offset][l] <= ^din[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= accept_rd && in_range && par_mismatch;
  end

  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Per-bank read registers only load on a read of their own bank, so the
  // registered bank select keeps dout stable across later writes/idles.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (init_wr) begin
        mem[b][cnt_q] <= '0;
      end else if (accept_wr && bank_idx == BW'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          if (we[l]) mem[b][offset][l*8 +: 8] <= din[l*8 +: 8];
        end
      end
      if (accept_rd && bank_idx == BW'(b)) rdata_q[b] <= mem[b][offset];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      oor_q       <= 1'b0;
      init_done_q <= 1'b0;
      dout_zero_q <= 1'b1;
      bank_sel_q  <= '0;
    end else begin
      ack_q       <= accept_wr || accept_rd;
      oor_q       <= (accept_wr || accept_rd) && !in_range;
      init_done_q <= (state_q == IDLE);
      if (accept_rd) begin
        bank_sel_q  <= bank_idx;
        dout_zero_q <= !in_range;
      end
    end
  end

  always_comb begin
    dout_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_q == BW'(b)) dout_mux = rdata_q[b];
    end
  end

  assign dout      = dout_zero_q ? '0 : dout_mux;
  assign ack       = ack_q;
  assign oor       = oor_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_banked_sram_ctrl.sv
module tb_banked_sram_ctrl;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BAW   = 12;
  localparam int NB    = 3;
  localparam int DEPTH = 1 << BAW;
  localparam int TOTAL = NB * DEPTH;
  localparam int INIT_CYCLES = DEPTH + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [3:0]    we;
  logic          re;
  logic          ack;
  logic [DW-1:0] dout;
  logic          oor;
  logic          init_done;
  logic          parity_err;

  always #5 clk = ~clk;

  banked_sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .re(re),
    .ack(ack), .dout(dout), .oor(oor), .init_done(init_done),
    .parity_err(parity_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        o;
    logic        p;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [TOTAL];
  logic [31:0] last_rd;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < TOTAL; i++) model[i] = '0;
    last_rd = '0;
  endtask

  // Monitor: exactly one expectation is pending for every cycle that must ack.
  initial begin
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        have = (sb.size() > 0);
        check("ack", 32'(ack), 32'(have));
        if (have) begin
          e = sb.pop_front();
          if (ack) begin
            check("dout", dout, e.d);
            check("oor", 32'(oor), 32'(e.o));
            check("parity_err", 32'(parity_err), 32'(e.p));
          end
        end
      end
    end
  end

  // Drive one request for one cycle; expectation is pushed after the sampling edge.
  task automatic req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w,
                     input logic r, input logic p = 1'b0);
    bit   live;
    bit   inr;
    exp_t e;
    live = init_done && !reset;
    inr  = (int'(a) < TOTAL);
    addr = a; din = d; we = w; re = r;
    @(posedge clk);
    if (live && (w != 0 || r)) begin
      if (w != 0) begin
        if (inr)
          for (int l = 0; l < 4; l++)
            if (w[l]) model[a][l*8 +: 8] = d[l*8 +: 8];
      end else begin
        last_rd = inr ? model[a] : 32'h0;
      end
      e.d = last_rd; e.o = !inr; e.p = p && (w == 0) && inr;
      sb.push_back(e);
    end
    #1;
    we = '0; re = 1'b0;
  endtask

  task automatic wait_init(input string name, input int start);
    int n = start;
    while (!init_done && n < INIT_CYCLES + 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, INIT_CYCLES);
  endtask

  initial begin
    reset = 1'b1; addr = '0; din = '0; we = '0; re = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_dout", dout, 0);
    check("rst_oor", 32'(oor), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    mon_en = 1;
    reset = 1'b0;

    // Requests during init must be ignored (no ack, no memory change).
    repeat (9) begin @(posedge clk); #1; end
    req(14'h0005, 32'hFFFFFFFF, 4'hF, 1'b0);
    req(14'h0000, 32'h0, 4'h0, 1'b1);
    wait_init("init_latency", 11);

    req(14'h0000, 0, 0, 1); req(14'h0FFF, 0, 0, 1); req(14'h2FFF, 0, 0, 1);
    req(14'h0005, 0, 0, 1);

    // Byte write
    req(14'h1005, 32'h11223344, 4'hF, 0);
    req(14'h1005, 32'hAABBCCDD, 4'h2, 0);
    req(14'h1005, 0, 0, 1);

    // Bank boundary
    req(14'h0FFF, 32'hDEADBEEF, 4'hF, 0);
    req(14'h1000, 32'h12345678, 4'hF, 0);
    req(14'h0FFF, 0, 0, 1);
    req(14'h1000, 0, 0, 1);

    // Out of range
    req(14'h3000, 32'hFFFFFFFF, 4'hF, 0);
    req(14'h3000, 0, 0, 1);
    req(14'h0000, 0, 0, 1);
    req(14'h2000, 0, 0, 1);

    // Simultaneous we + re: write wins, dout holds
    req(14'h0010, 32'h5, 4'hF, 0);
    req(14'h0010, 0, 0, 1);
    req(14'h0010, 32'h9, 4'hF, 1);
    req(14'h0010, 0, 0, 1);

`ifdef SRAM_BYTE_PARITY_EN
    req(14'h0020, 32'h00000001, 4'hF, 0);
    dut.par_mem[0][32][0] = ~dut.par_mem[0][32][0];
    req(14'h0020, 0, 0, 1, 1'b1);
    req(14'h0021, 0, 0, 1);
`endif

    // Randomized traffic, including out-of-range bank 3
    for (int i = 0; i < 400; i++) begin
      logic [1:0]     bk;
      logic [BAW-1:0] off;
      logic [3:0]     w;
      bk  = 2'($urandom_range(0, 3));
      off = ($urandom_range(0, 3) == 0) ? BAW'($urandom) : BAW'($urandom_range(0, 7));
      w   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      req({bk, off}, $urandom, w, 1'($urandom));
    end

    // Reset during a read: no ack, init restarts, contents re-zeroed
    addr = 14'h1005; re = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
    @(posedge clk); #1;
    check("reset_init_done_drop", 32'(init_done), 0);
    reset = 1'b0;
    clear_model();
    wait_init("reinit_latency", 0);
    req(14'h1005, 0, 0, 1);
    req(14'h0010, 0, 0, 1);

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
